coin_collector: RTL and testbench
=================================

COIN_COLLECTOR -- requirements
Module: coin_collector

Interface
REQ-001 SHALL have parameter NUM_COINS, default 8: number of coin slots tracked.
REQ-002 SHALL have parameter SKY, default 1: tile code written over a collected coin.
REQ-003 SHALL have parameter BLOCK_WIDTH, default 40: pixels per tile, used for the animation origin.
REQ-004 SHALL have parameter ANIM_FRAMES, default 16: pop-up animation length in frame ticks.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-006 SHALL have port reset, input, 1: synchronous active-high reset, sampled on posedge clk.
REQ-007 SHALL have port touch, input, NUM_COINS: per-slot Mario/coin overlap level from the per-coin detectors.
REQ-008 SHALL have port coin_tx, input, NUM_COINS x 5: tile column of each slot.
REQ-009 SHALL have port coin_ty, input, NUM_COINS x 5: tile row of each slot.
REQ-010 SHALL have port level_load, input, 1: one-cycle pulse that restores all coins.
REQ-011 SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-012 SHALL have port present, output, NUM_COINS: 1 = coin still in the level.
REQ-013 SHALL have tile write port outputs tile_we (1), tile_x (5), tile_y (5), tile_data (3), plus input tile_ack (1).
REQ-014 SHALL have port coin_count, output, 8: two BCD digits, tens in [7:4].
REQ-015 SHALL have port life_up, output, 1: one-cycle pulse on count wrap.
REQ-016 SHALL have ports anim_active (1), anim_px (10), anim_py (10), all outputs: pop-up sprite state.

Function
REQ-017 SHALL register touch into a pending bit for slot i when touch[i]=1 and present[i]=1; a touch on an absent slot is ignored.
REQ-018 SHALL implement FSM states IDLE, WRITE and COUNT.
REQ-019 IDLE: if any pending bit is set, SHALL select the lowest-index pending slot, latch its tile coordinates, clear its pending and present bits, and enter WRITE next cycle.
REQ-020 WRITE: SHALL hold tile_we=1, tile_x/tile_y = latched slot coordinates, tile_data=SKY.
REQ-021 WRITE: SHALL stay in WRITE until tile_ack=1 is sampled, then enter COUNT; tile_we SHALL drop the cycle after the ack.
REQ-022 COUNT: SHALL BCD-increment coin_count and return to IDLE, so one collection takes a minimum of 3 cycles with tile_ack tied high.
REQ-023 SHALL increment coin_count as follows: ones 9 rolls to 0 with a tens carry; 99 wraps to 00 and pulses life_up for exactly one cycle in the cycle after COUNT.
REQ-024 SHALL process simultaneous touches on multiple slots one per FSM pass, in ascending index order, with none lost.
REQ-025 SHALL keep a held touch level from re-collecting a slot, because present is already 0.
REQ-026 SHALL start the animation on the cycle COUNT is entered: anim_active=1, anim_px=tx*BLOCK_WIDTH, anim_py=ty*BLOCK_WIDTH, frame counter=0.
REQ-027 SHALL, while the animation is active, increment the frame counter and decrement anim_py by 2 on each frame_tick (saturating at 0); after ANIM_FRAMES ticks anim_active SHALL go to 0.
REQ-028 SHALL restart the animation from the new coin's origin if a new collection occurs while one is already active.
REQ-029 On level_load, SHALL set present to all ones and clear pending, the FSM, tile_we and anim_active to idle values; coin_count is retained.
REQ-030 SHALL resolve a collision between level_load and touch in favour of level_load, with the touch dropped.
REQ-031 SHALL resolve a level_load during WRITE by abandoning the write; tile_we SHALL be 0 the next cycle.

Reset
REQ-032 On reset, SHALL set present to all ones and pending to 0, put the FSM in IDLE, and drive tile_we=0, tile_x=0, tile_y=0, tile_data=0, coin_count=8'h00, life_up=0, anim_active=0, anim_px=0, anim_py=0.
REQ-033 Reset SHALL take priority over every other input, including a reset asserted mid-WRITE.

Verification
REQ-034 Single coin: tile_ack tied 1, touch[2]=1 with coin_tx[2]=5 and coin_ty[2]=8 -> tile_we for 1 cycle with x=5, y=8, data=1; coin_count=01; present[2]=0; anim_px=200, anim_py=320.
REQ-035 Simultaneous touches: touch=8'b1001_0001 in one cycle -> three writes for slots 0, 4 and 7 in that order; coin_count=03.
REQ-036 Slow ack: tile_ack delayed 5 cycles -> tile_we held for 6 cycles with stable coordinates; count increments once.
REQ-037 Wrap: preload coin_count to 99 through collections, then collect one more -> coin_count=00 and a single one-cycle life_up pulse.
REQ-038 Animation: 16 frame_ticks after collection at anim_py=320 -> anim_py=288 and anim_active=0; a second collection at tick 8 restarts the animation from the new origin.
REQ-039 level_load and reset mid-WRITE -> tile_we=0 next cycle and present all ones; after level_load coin_count is unchanged, after reset it is 00.

Source files
------------

// File: rtl/coin_collector.sv
// Coin collector: latches Mario/coin overlaps, erases each collected coin from
// the tile map through a handshaked write port, keeps a two-digit BCD coin
// count with a 1-up pulse on wrap, and drives a short pop-up sprite animation.
module coin_collector #(
  parameter int NUM_COINS   = 8,
  parameter int SKY         = 1,
  parameter int BLOCK_WIDTH = 40,
  parameter int ANIM_FRAMES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_COINS-1:0]   touch,
  input  logic [NUM_COINS*5-1:0] coin_tx,
  input  logic [NUM_COINS*5-1:0] coin_ty,
  input  logic                   level_load,
  input  logic                   frame_tick,
  output logic [NUM_COINS-1:0]   present,
  output logic                   tile_we,
  output logic [4:0]             tile_x,
  output logic [4:0]             tile_y,
  output logic [2:0]             tile_data,
  input  logic                   tile_ack,
  output logic [7:0]             coin_count,
  output logic                   life_up,
  output logic                   anim_active,
  output logic [9:0]             anim_px,
  output logic [9:0]             anim_py
);

  localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam int FC_W  = $clog2(ANIM_FRAMES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;

  logic [1:0]           state_reg;
  logic [NUM_COINS-1:0] present_reg;
  logic [NUM_COINS-1:0] pending_reg;
  logic                 tile_we_reg;
  logic [4:0]           tile_x_reg;
  logic [4:0]           tile_y_reg;
  logic [2:0]           tile_data_reg;
  logic [7:0]           coin_count_reg;
  logic [7:0]           coin_count_next;
  logic                 wrap_next;
  logic                 life_up_reg;
  logic                 anim_active_reg;
  logic [9:0]           anim_px_reg;
  logic [9:0]           anim_py_reg;
  logic [FC_W-1:0]      frame_cnt_reg;

  logic [4:0]           tx_arr [NUM_COINS];
  logic [4:0]           ty_arr [NUM_COINS];
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_valid;
  logic [NUM_COINS-1:0] sel_onehot;
  logic [NUM_COINS-1:0] clear_mask;
  logic                 take;
  logic                 anim_start;

  // Unpack the flat coordinate buses and build the one-hot of the chosen slot
  genvar gi;
  generate
    for (gi = 0; gi < NUM_COINS; gi++) begin : g_slot
      assign tx_arr[gi]     = coin_tx[gi*5 +: 5];
      assign ty_arr[gi]     = coin_ty[gi*5 +: 5];
      assign sel_onehot[gi] = sel_valid && (sel_idx == IDX_W'(gi));
    end
  endgenerate

  // Lowest-index pending slot wins: scan downward so the last hit is the lowest
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (pending_reg[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_valid  = |pending_reg;
  assign take       = (state_reg == ST_IDLE) && sel_valid;
  assign clear_mask = take ? sel_onehot : '0;
  assign anim_start = (state_reg == ST_WRITE) && tile_ack;

  // Two-digit BCD increment; 99 wraps to 00 and flags a 1-up
  always_comb begin
    coin_count_next = coin_count_reg;
    wrap_next       = 1'b0;
    if (coin_count_reg[3:0] == 4'd9) begin
      if (coin_count_reg[7:4] == 4'd9) begin
        coin_count_next = 8'h00;
        wrap_next       = 1'b1;
      end else begin
        coin_count_next = {coin_count_reg[7:4] + 4'd1, 4'd0};
      end
    end else begin
      coin_count_next = {coin_count_reg[7:4], coin_count_reg[3:0] + 4'd1};
    end
  end

  // Pending/present bookkeeping; the clear mask also kills a touch held on the
  // slot being taken, so a held level cannot re-arm it
  always_ff @(posedge clk) begin
    if (reset || level_load) begin
      present_reg <= '1;
      pending_reg <= '0;
    end else begin
      pending_reg <= (pending_reg | (touch & present_reg)) & ~clear_mask;
      present_reg <= present_reg & ~clear_mask;
    end
  end

  // Collection FSM driving the tile write handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      tile_we_reg   <= 1'b0;
      tile_x_reg    <= 5'd0;
      tile_y_reg    <= 5'd0;
      tile_data_reg <= 3'd0;
    end else if (level_load) begin
      state_reg   <= ST_IDLE;
      tile_we_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (sel_valid) begin
            tile_x_reg    <= tx_arr[sel_idx];
            tile_y_reg    <= ty_arr[sel_idx];
            tile_data_reg <= 3'(SKY);
            tile_we_reg   <= 1'b1;
            state_reg     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (tile_ack) begin
            tile_we_reg <= 1'b0;
            state_reg   <= ST_COUNT;
          end
        end
        ST_COUNT: state_reg <= ST_IDLE;
        default: begin
          state_reg   <= ST_IDLE;
          tile_we_reg <= 1'b0;
        end
      endcase
    end
  end

  // Coin counter and 1-up pulse; level_load keeps the count
  always_ff @(posedge clk) begin
    if (reset) begin
      coin_count_reg <= 8'h00;
      life_up_reg    <= 1'b0;
    end else begin
      life_up_reg <= 1'b0;
      if (!level_load && state_reg == ST_COUNT) begin
        coin_count_reg <= coin_count_next;
        life_up_reg    <= wrap_next;
      end
    end
  end

  // Pop-up animation: starts (or restarts) on entry to COUNT, rises 2 px per frame
  always_ff @(posedge clk) begin
    if (reset) begin
      anim_active_reg <= 1'b0;
      anim_px_reg     <= 10'd0;
      anim_py_reg     <= 10'd0;
      frame_cnt_reg   <= '0;
    end else if (level_load) begin
      anim_active_reg <= 1'b0;
      frame_cnt_reg   <= '0;
    end else if (anim_start) begin
      anim_active_reg <= 1'b1;
      anim_px_reg     <= 10'(int'(tile_x_reg) * BLOCK_WIDTH);
      anim_py_reg     <= 10'(int'(tile_y_reg) * BLOCK_WIDTH);
      frame_cnt_reg   <= '0;
    end else if (anim_active_reg && frame_tick) begin
      frame_cnt_reg <= frame_cnt_reg + FC_W'(1);
      anim_py_reg   <= (anim_py_reg >= 10'd2) ? anim_py_reg - 10'd2 : 10'd0;
      if (frame_cnt_reg == FC_W'(ANIM_FRAMES - 1)) anim_active_reg <= 1'b0;
    end
  end

  assign present     = present_reg;
  assign tile_we     = tile_we_reg;
  assign tile_x      = tile_x_reg;
  assign tile_y      = tile_y_reg;
  assign tile_data   = tile_data_reg;
  assign coin_count  = coin_count_reg;
  assign life_up     = life_up_reg;
  assign anim_active = anim_active_reg;
  assign anim_px     = anim_px_reg;
  assign anim_py     = anim_py_reg;

endmodule

// File: tb/tb_coin_collector.sv
// Directed bench for coin_collector: expected tile writes are queued when a
// touch is driven and compared when the write handshake completes.
module tb_coin_collector;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   touch = '0;
  logic [N*5-1:0] coin_tx;
  logic [N*5-1:0] coin_ty;
  logic           level_load = 1'b0;
  logic           frame_tick = 1'b0;
  logic [N-1:0]   present;
  logic           tile_we;
  logic [4:0]     tile_x;
  logic [4:0]     tile_y;
  logic [2:0]     tile_data;
  logic           tile_ack = 1'b1;
  logic [7:0]     coin_count;
  logic           life_up;
  logic           anim_active;
  logic [9:0]     anim_px;
  logic [9:0]     anim_py;

  typedef struct {
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  passed = 0;
  int  total = 0;
  int  we_cycles = 0;
  int  life_cnt = 0;

  coin_collector #(.NUM_COINS(N), .SKY(1), .BLOCK_WIDTH(40), .ANIM_FRAMES(16)) dut (
    .clk(clk), .reset(reset), .touch(touch), .coin_tx(coin_tx), .coin_ty(coin_ty),
    .level_load(level_load), .frame_tick(frame_tick), .present(present),
    .tile_we(tile_we), .tile_x(tile_x), .tile_y(tile_y), .tile_data(tile_data),
    .tile_ack(tile_ack), .coin_count(coin_count), .life_up(life_up),
    .anim_active(anim_active), .anim_px(anim_px), .anim_py(anim_py)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_slot(input int s);
    wr_t w;
    w.x = 5'(s + 3);
    w.y = 5'(s + 6);
    w.d = 3'd1;
    exp_q.push_back(w);
  endtask

  task automatic pulse_touch(input logic [N-1:0] t);
    touch = t;
    tick();
    touch = '0;
  endtask

  task automatic pulse_load();
    level_load = 1'b1;
    tick();
    level_load = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
  endtask

  task automatic wait_we();
    int k;
    k = 0;
    while (tile_we !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("wait_tile_we", 32'(tile_we), 32'd1);
  endtask

  // Write monitor: coordinates must match the queued expectation on every
  // cycle tile_we is high; the entry retires when the ack is sampled
  always @(negedge clk) begin
    if (!reset) begin
      if (life_up) begin
        life_cnt++;
        check("life_up_count_zero", 32'(coin_count), 32'h00);
      end
      if (tile_we) begin
        we_cycles++;
        if (exp_q.size() > 0) begin
          check("wr_x", 32'(tile_x), 32'(exp_q[0].x));
          check("wr_y", 32'(tile_y), 32'(exp_q[0].y));
          check("wr_data", 32'(tile_data), 32'(exp_q[0].d));
          $display("write x=%0d y=%0d data=%0d ack=%0b", tile_x, tile_y, tile_data, tile_ack);
          if (tile_ack) void'(exp_q.pop_front());
        end else begin
          check("wr_unexpected", 32'(exp_q.size()), 32'd1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      coin_tx[i*5 +: 5] = 5'(i + 3);
      coin_ty[i*5 +: 5] = 5'(i + 6);
    end

    // Reset state
    ticks(2);
    check("rst_present", 32'(present), 32'hff);
    check("rst_tile_we", 32'(tile_we), 32'd0);
    check("rst_tile_x", 32'(tile_x), 32'd0);
    check("rst_tile_y", 32'(tile_y), 32'd0);
    check("rst_tile_data", 32'(tile_data), 32'd0);
    check("rst_count", 32'(coin_count), 32'h00);
    check("rst_life_up", 32'(life_up), 32'd0);
    check("rst_anim_active", 32'(anim_active), 32'd0);
    check("rst_anim_px", 32'(anim_px), 32'd0);
    check("rst_anim_py", 32'(anim_py), 32'd0);
    reset = 1'b0;
    tick();

    // Single coin, touch held for several cycles must collect once
    we_cycles = 0;
    push_slot(2);
    touch = 8'b0000_0100;
    ticks(4);
    touch = '0;
    ticks(10);
    check("single_count", 32'(coin_count), 32'h01);
    check("single_we_cycles", 32'(we_cycles), 32'd1);
    check("single_present2", 32'(present[2]), 32'd0);
    check("single_anim_px", 32'(anim_px), 32'd200);
    check("single_anim_py", 32'(anim_py), 32'd320);
    check("single_anim_active", 32'(anim_active), 32'd1);

    // Full animation run
    frames(16);
    check("anim16_py", 32'(anim_py), 32'd288);
    check("anim16_active", 32'(anim_active), 32'd0);

    // Restart mid-animation
    push_slot(3);
    pulse_touch(8'b0000_1000);
    ticks(10);
    frames(8);
    check("anim8_py", 32'(anim_py), 32'd344);
    check("anim8_active", 32'(anim_active), 32'd1);
    push_slot(5);
    pulse_touch(8'b0010_0000);
    ticks(10);
    check("restart_px", 32'(anim_px), 32'd320);
    check("restart_py", 32'(anim_py), 32'd440);
    check("restart_active", 32'(anim_active), 32'd1);
    frames(15);
    check("restart15_py", 32'(anim_py), 32'd410);
    check("restart15_active", 32'(anim_active), 32'd1);
    frames(1);
    check("restart16_py", 32'(anim_py), 32'd408);
    check("restart16_active", 32'(anim_active), 32'd0);
    check("anim_count", 32'(coin_count), 32'h03);

    // Simultaneous touches: slots 0, 4, 7 in order
    push_slot(0);
    push_slot(4);
    push_slot(7);
    pulse_touch(8'b1001_0001);
    ticks(25);
    check("multi_count", 32'(coin_count), 32'h06);
    check("multi_present", 32'(present), 32'b0100_0010);

    // Level load restores coins, keeps count
    pulse_load();
    check("load_present", 32'(present), 32'hff);
    check("load_count", 32'(coin_count), 32'h06);

    // Slow ack: five cycles without ack, sixth acknowledges
    tile_ack = 1'b0;
    we_cycles = 0;
    push_slot(1);
    pulse_touch(8'b0000_0010);
    wait_we();
    ticks(5);
    tile_ack = 1'b1;
    ticks(8);
    check("slow_we_cycles", 32'(we_cycles), 32'd6);
    check("slow_count", 32'(coin_count), 32'h07);

    // level_load during WRITE abandons the write
    tile_ack = 1'b0;
    push_slot(2);
    pulse_touch(8'b0000_0100);
    wait_we();
    pulse_load();
    check("ldw_tile_we", 32'(tile_we), 32'd0);
    check("ldw_present", 32'(present), 32'hff);
    check("ldw_count", 32'(coin_count), 32'h07);
    void'(exp_q.pop_front());
    tile_ack = 1'b1;

    // level_load colliding with a touch drops the touch
    level_load = 1'b1;
    touch = 8'b0000_0001;
    tick();
    level_load = 1'b0;
    touch = '0;
    ticks(10);
    check("coll_count", 32'(coin_count), 32'h07);
    check("coll_present", 32'(present), 32'hff);

    // Reset during WRITE
    tile_ack = 1'b0;
    push_slot(3);
    pulse_touch(8'b0000_1000);
    wait_we();
    reset = 1'b1;
    tick();
    check("rstw_tile_we", 32'(tile_we), 32'd0);
    check("rstw_present", 32'(present), 32'hff);
    check("rstw_count", 32'(coin_count), 32'h00);
    check("rstw_anim_active", 32'(anim_active), 32'd0);
    void'(exp_q.pop_front());
    reset = 1'b0;
    tile_ack = 1'b1;
    tick();

    // Count up to 99, then wrap
    for (int b = 0; b < 12; b++) begin
      pulse_load();
      for (int s = 0; s < N; s++) push_slot(s);
      pulse_touch(8'hff);
      ticks(40);
    end
    pulse_load();
    for (int s = 0; s < 3; s++) push_slot(s);
    pulse_touch(8'h07);
    ticks(20);
    check("pre_wrap_count", 32'(coin_count), 32'h99);
    check("pre_wrap_life", 32'(life_cnt), 32'd0);
    push_slot(3);
    pulse_touch(8'h08);
    ticks(10);
    check("wrap_count", 32'(coin_count), 32'h00);
    check("wrap_life_pulses", 32'(life_cnt), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
